// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock decision stage.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package lock_pkg;

  // Display/state codes driven on lockState
  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } stateT;

  // Password in force after reset (one-hot key codes, first key in the MS nibble)
  localparam logic [23:0] DEFAULT_PASSWORD = 24'h128482;

  // Timer load for a duration in seconds; the timer counts down to zero and the
  // expire pulse lands one cycle later, so the state is held exactly seconds*frequency cycles.
  function automatic longint unsigned secondsToCycles(input longint unsigned seconds,
                                                      input longint unsigned frequency);
    return seconds * frequency - 64'd1;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter used for the unlock, program and lockout windows.
// Latency: expire pulses one cycle after the count reaches zero.
// Backpressure: none; a load always wins and cancels any pending expire.
module lock_timer #(
  parameter int TIMER_WIDTH = 40
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] loadValue,
  output logic                   expire,
  output logic                   busy
);

  logic [TIMER_WIDTH-1:0] count;

  // Count down while nonzero; flag the 1 -> 0 step as a single-cycle expire pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      count  <= loadValue;
      expire <= 1'b0;
    end else begin
      expire <= (count == TIMER_WIDTH'(1));
      if (count != '0) begin
        count <= count - TIMER_WIDTH'(1);
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/lock_controller.sv
// Digital-lock decision stage: checks completed key entries against the stored password.
// Latency: outputs registered, updating one cycle after the key count reaches KEY_NUMBERS.
// Backpressure: none; each completed entry is evaluated once, in the cycle it completes.
module lock_controller #(
  parameter int KEY_WIDTH               = 4,
  parameter int KEY_NUMBERS             = 6,
  parameter int KEY_NUMBERS_STORE_WIDTH = 3,
  parameter int CLOCK_FREQUENCY         = 50_000_000,
  parameter int TIMER_WIDTH             = 40,
  parameter int UNLOCK_TIME             = 5,
  parameter int LOCKOUT_TIME            = 10,
  parameter int MAX_ATTEMPTS            = 3,
  parameter logic [KEY_WIDTH*KEY_NUMBERS-1:0] DEFAULT_PASSWORD = lock_pkg::DEFAULT_PASSWORD
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [KEY_WIDTH*KEY_NUMBERS-1:0]   keyValueStore,
  input  logic [KEY_NUMBERS_STORE_WIDTH-1:0] keyNumbersStore,
  input  logic                               timeValueFlag,
  input  logic                               changeRequest,
  output logic                               unlocked,
  output logic                               alarm,
  output logic [1:0]                         attemptsLeft,
  output logic [1:0]                         lockState
);
  import lock_pkg::*;

  // attemptsLeft is only 2 bits wide
  if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3) begin : gMaxAttemptsCheck
    $error("lock_controller: MAX_ATTEMPTS must be in 1..3");
  end

  localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);
  localparam logic [KEY_NUMBERS_STORE_WIDTH-1:0] FULL_COUNT = KEY_NUMBERS_STORE_WIDTH'(KEY_NUMBERS);
  localparam logic [TIMER_WIDTH-1:0] UNLOCK_LOAD =
    TIMER_WIDTH'(secondsToCycles(64'(UNLOCK_TIME), 64'(CLOCK_FREQUENCY)));
  localparam logic [TIMER_WIDTH-1:0] LOCKOUT_LOAD =
    TIMER_WIDTH'(secondsToCycles(64'(LOCKOUT_TIME), 64'(CLOCK_FREQUENCY)));

  stateT                               state;
  logic [KEY_WIDTH*KEY_NUMBERS-1:0]    storedPassword;
  logic [KEY_NUMBERS_STORE_WIDTH-1:0]  prevCount;
  logic                                prevTimeout;
  logic                                entryDone;
  logic                                toEdge;
  logic                                match;
  logic                                timerExpire;
  logic                                timerBusy;
  logic                                timerExpired;
  logic                                loadUnlock;
  logic                                loadLockout;
  logic                                timerLoad;
  logic [TIMER_WIDTH-1:0]              timerLoadValue;

  // One strobe per entry: the count must arrive at full, not merely sit there
  assign entryDone = (keyNumbersStore == FULL_COUNT) && (prevCount != FULL_COUNT);
  assign toEdge    = timeValueFlag && !prevTimeout;
  assign match     = (keyValueStore == storedPassword);
  // Only honour a pulse from a timer that has actually run down
  assign timerExpired = timerExpire && !timerBusy;

  // Timer (re)loads happen on the same edge as the state change they time
  always_comb begin
    loadUnlock     = 1'b0;
    loadLockout    = 1'b0;
    if (state == LOCKED && entryDone) begin
      loadUnlock  = match;
      loadLockout = !match && (attemptsLeft <= 2'd1);
    end
    if (state == UNLOCKED && !timerExpired && changeRequest) begin
      loadUnlock = 1'b1;
    end
    timerLoad      = loadUnlock || loadLockout;
    timerLoadValue = loadLockout ? LOCKOUT_LOAD : UNLOCK_LOAD;
  end

  lock_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) uTimer (
    .clock    (clock),
    .reset    (reset),
    .load     (timerLoad),
    .loadValue(timerLoadValue),
    .expire   (timerExpire),
    .busy     (timerBusy)
  );

  // Lock FSM with registered outputs; edge detectors track inputs in every state
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= LOCKED;
      unlocked       <= 1'b0;
      alarm          <= 1'b0;
      attemptsLeft   <= MAX_ATT;
      storedPassword <= DEFAULT_PASSWORD;
      prevCount      <= '0;
      prevTimeout    <= 1'b0;
    end else begin
      prevCount   <= keyNumbersStore;
      prevTimeout <= timeValueFlag;
      unique case (state)
        LOCKED: begin
          if (entryDone) begin
            if (match) begin
              state        <= UNLOCKED;
              unlocked     <= 1'b1;
              attemptsLeft <= MAX_ATT;
            end else if (attemptsLeft > 2'd1) begin
              attemptsLeft <= attemptsLeft - 2'd1;
            end else begin
              state        <= LOCKOUT;
              alarm        <= 1'b1;
              attemptsLeft <= 2'd0;
            end
          end
        end
        UNLOCKED: begin
          if (timerExpired) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end else if (changeRequest) begin
            state <= PROGRAM;
          end
        end
        PROGRAM: begin
          if (timerExpired || toEdge) begin
            state    <= LOCKED;
            unlocked <= 1'b0;
          end else if (entryDone) begin
            storedPassword <= keyValueStore;
            state          <= LOCKED;
            unlocked       <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timerExpired) begin
            state        <= LOCKED;
            alarm        <= 1'b0;
            attemptsLeft <= MAX_ATT;
          end
        end
      endcase
    end
  end

  assign lockState = state;

endmodule

// File: tb/tb_lock_controller.sv
// Randomised scoreboard bench for lock_controller.
// Latency: expectations are time-stamped with the clock edge at which outputs must change.
// Backpressure: n/a.
module tb_lock_controller;

  localparam int UNLOCK_CYC  = 500;
  localparam int LOCKOUT_CYC = 1000;
  localparam int MAXA        = 3;
  localparam logic [23:0] DEF_PASS = 24'h128482;
  localparam int M_LOCKED = 0, M_UNLOCKED = 1, M_PROGRAM = 2, M_LOCKOUT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] keyValueStore;
  logic [2:0]  keyNumbersStore;
  logic        timeValueFlag;
  logic        changeRequest;
  logic        unlocked;
  logic        alarm;
  logic [1:0]  attemptsLeft;
  logic [1:0]  lockState;

  lock_controller #(
    .CLOCK_FREQUENCY(100),
    .UNLOCK_TIME    (5),
    .LOCKOUT_TIME   (10)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .keyValueStore  (keyValueStore),
    .keyNumbersStore(keyNumbersStore),
    .timeValueFlag  (timeValueFlag),
    .changeRequest  (changeRequest),
    .unlocked       (unlocked),
    .alarm          (alarm),
    .attemptsLeft   (attemptsLeft),
    .lockState      (lockState)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } expT;

  expT expQ[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // Reference model: mode, attempts, password and the edge at which the current window ends
  int          mMode;
  int          mAttempts;
  int          mDeadline;
  logic [23:0] mPass;
  logic [5:0]  mLast;

  function automatic logic [5:0] modelView();
    return {(mMode == M_UNLOCKED || mMode == M_PROGRAM), (mMode == M_LOCKOUT),
            2'(mAttempts), 2'(mMode)};
  endfunction

  function automatic void pushIfChanged(int e);
    expT x;
    x.cyc = e;
    x.val = modelView();
    if (x.val !== mLast) begin
      expQ.push_back(x);
      mLast = x.val;
    end
  endfunction

  function automatic bit windowEndsAt(int e);
    return (mMode != M_LOCKED) && (mDeadline == e);
  endfunction

  function automatic void modelReset(int e);
    mMode     = M_LOCKED;
    mAttempts = MAXA;
    mPass     = DEF_PASS;
    mDeadline = 0;
    pushIfChanged(e);
  endfunction

  function automatic void modelExpire(int e);
    if (windowEndsAt(e)) begin
      if (mMode == M_LOCKOUT) mAttempts = MAXA;
      mMode = M_LOCKED;
      pushIfChanged(e);
    end
  endfunction

  function automatic void modelEntry(int e, logic [23:0] code);
    if (windowEndsAt(e)) return;
    if (mMode == M_LOCKED) begin
      if (code == mPass) begin
        mMode     = M_UNLOCKED;
        mAttempts = MAXA;
        mDeadline = e + UNLOCK_CYC;
      end else if (mAttempts > 1) begin
        mAttempts = mAttempts - 1;
      end else begin
        mMode     = M_LOCKOUT;
        mAttempts = 0;
        mDeadline = e + LOCKOUT_CYC;
      end
    end else if (mMode == M_PROGRAM) begin
      mPass = code;
      mMode = M_LOCKED;
    end
    pushIfChanged(e);
  endfunction

  function automatic void modelTimeout(int e);
    if (windowEndsAt(e)) return;
    if (mMode == M_PROGRAM) mMode = M_LOCKED;
    pushIfChanged(e);
  endfunction

  function automatic void modelChange(int e);
    if (windowEndsAt(e)) return;
    if (mMode == M_UNLOCKED) begin
      mMode     = M_PROGRAM;
      mDeadline = e + UNLOCK_CYC;
    end
    pushIfChanged(e);
  endfunction

  function automatic logic [23:0] randCode();
    logic [23:0] c;
    logic [3:0]  k;
    c = '0;
    for (int i = 0; i < 6; i++) begin
      k = 4'b0001;
      k = k << $urandom_range(0, 3);
      c = {c[19:0], k};
    end
    return c;
  endfunction

  // Monitor: every change of the output tuple must match the next expectation, edge for edge
  logic [5:0] seen = 'x;
  always @(negedge clock) begin
    logic [5:0] cur;
    expT        x;
    cur = {unlocked, alarm, attemptsLeft, lockState};
    if (cur !== seen) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change at cyc %0d: got u/a/att/st=%b, required no change", cyc, cur);
      end else begin
        x = expQ.pop_front();
        if (x.cyc != cyc || x.val !== cur) begin
          miscompares++;
          $display("FAIL output_change: got %b at cyc %0d, required %b at cyc %0d",
                   cur, cyc, x.val, x.cyc);
        end
      end
      seen = cur;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    modelExpire(cyc);
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic enterCode(logic [23:0] code, int hold);
    for (int i = 1; i <= 6; i++) begin
      keyValueStore   = code >> (4 * (6 - i));
      keyNumbersStore = 3'(i);
      if (i == 6) modelEntry(cyc + 1, code);
      tick();
      if (i < 6) idle($urandom_range(0, 3));
    end
    idle(hold);
    keyNumbersStore = '0;
    keyValueStore   = '0;
    tick();
  endtask

  task automatic pulseTimeout();
    timeValueFlag = 1'b1;
    modelTimeout(cyc + 1);
    tick();
    timeValueFlag = 1'b0;
    tick();
  endtask

  task automatic pulseChange();
    changeRequest = 1'b1;
    modelChange(cyc + 1);
    tick();
    changeRequest = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    modelReset(cyc + 1);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    keyValueStore   = '0;
    keyNumbersStore = '0;
    timeValueFlag   = 1'b0;
    changeRequest   = 1'b0;
    mLast           = 'x;
    modelReset(1);
    idle(3);
    reset = 1'b0;
    idle(2);

    // Correct entry, then the unlock window runs out
    enterCode(DEF_PASS, 2);
    idle(UNLOCK_CYC + 10);

    // Three wrong entries into lockout; a correct entry during lockout is ignored
    repeat (3) enterCode(24'h111111, 1);
    enterCode(DEF_PASS, 1);
    idle(LOCKOUT_CYC + 10);

    // Program mode aborted by a key timeout keeps the old password
    enterCode(DEF_PASS, 1);
    pulseChange();
    idle(5);
    pulseTimeout();
    idle(3);
    enterCode(DEF_PASS, 1);
    idle(UNLOCK_CYC + 10);

    // Reprogram, old code now wrong, new code unlocks
    enterCode(DEF_PASS, 1);
    pulseChange();
    enterCode(24'h842148, 1);
    enterCode(DEF_PASS, 1);
    enterCode(24'h842148, 1);
    idle(UNLOCK_CYC + 10);

    // Count held at full for 50 cycles evaluates once
    enterCode(24'h111111, 50);
    idle(5);

    // Reset while unlocked restores the default password
    enterCode(24'h842148, 1);
    idle(20);
    applyReset();
    idle(2);
    enterCode(DEF_PASS, 1);
    idle(UNLOCK_CYC + 10);

    // Random operation mix
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0, 1:    enterCode(mPass, $urandom_range(0, 3));
        2:       enterCode(randCode(), $urandom_range(0, 3));
        3:       pulseChange();
        4:       pulseTimeout();
        5:       idle($urandom_range(1, 600));
        default: if ($urandom_range(0, 3) == 0) applyReset(); else idle($urandom_range(1, 20));
      endcase
    end
    idle(10);

    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL missing_changes: %0d expected output changes never seen, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
